wb_arb: RTL and testbench

WB_ARB -- requirements
Module: wb_arb

---
 rtl/wb_arb.sv | 92 +++++++++
 tb/tb_wb_arb.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/wb_arb.sv
// wb_arb: register-file write-port arbiter, ALU first, with a 2-entry in-order load FIFO.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   alu_valid, alu_rd, alu_data    ALU result offered this cycle (no backpressure)
//   ld_valid, ld_ready, ld_rd, ld_data   load result handshake
//   alu_stall                      upstream must hold alu_valid low next cycle
//   wren, rd_addr, reg_data        registered register-file write port
module wb_arb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        alu_stall,
  output logic        wren,
  output logic [4:0]  rd_addr,
  output logic [31:0] reg_data
);
  logic [4:0]  rd_q [2];
  logic [31:0] dat_q [2];
  logic [1:0]  vld_q, vld_d, kill_m, pop_m, push_m;
  logic        rp_q, rp_d, wp_q, wp_d;
  logic [1:0]  cnt_q, cnt_d, lead, pops;
  logic        stall_q, wren_q, wren_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [31:0] reg_data_q, reg_data_d;
  logic        alu_sel, occ0, occ1, ve0, ve1, fifo_wr, wi, push;

  assign alu_sel = alu_valid && alu_rd != 5'd0;
  assign occ0    = cnt_q != 2'd0;
  assign occ1    = cnt_q == 2'd2;
  assign kill_m  = {alu_sel && rd_q[1] == alu_rd, alu_sel && rd_q[0] == alu_rd};
  // An entry counts as valid only if a winning ALU write to the same rd does not supersede it.
  assign ve0     = occ0 && vld_q[rp_q] && !kill_m[rp_q];
  assign ve1     = occ1 && vld_q[~rp_q] && !kill_m[~rp_q];
  // Invalidated entries ahead of the first valid one are dropped for free.
  assign lead    = (occ0 && !ve0) ? ((occ1 && !ve1) ? 2'd2 : 2'd1) : 2'd0;
  assign fifo_wr = !alu_sel && (lead == 2'd0 ? ve0 : lead == 2'd1 ? ve1 : 1'b0);
  assign wi      = lead == 2'd0 ? rp_q : ~rp_q;
  assign pops    = lead + {1'b0, fifo_wr};
  assign ld_ready = rst_n && cnt_q != 2'd2;
  // A load targeting x0 or the same rd as the winning (younger) ALU result is accepted but dropped.
  assign push    = ld_valid && ld_ready && ld_rd != 5'd0 && !(alu_sel && ld_rd == alu_rd);
  assign pop_m   = pops == 2'd2 ? 2'b11 : pops == 2'd1 ? (rp_q ? 2'b10 : 2'b01) : 2'b00;
  assign push_m  = push ? (wp_q ? 2'b10 : 2'b01) : 2'b00;
  assign vld_d   = (vld_q & ~kill_m & ~pop_m) | push_m;
  assign cnt_d   = cnt_q - pops + {1'b0, push};
  assign rp_d    = rp_q ^ pops[0];
  assign wp_d    = wp_q ^ push;
  assign wren_d     = alu_sel || fifo_wr;
  assign rd_addr_d  = alu_sel ? alu_rd : fifo_wr ? rd_q[wi] : rd_addr_q;
  assign reg_data_d = alu_sel ? alu_data : fifo_wr ? dat_q[wi] : reg_data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q      <= 2'b00;
      rp_q       <= 1'b0;
      wp_q       <= 1'b0;
      cnt_q      <= 2'd0;
      stall_q    <= 1'b0;
      wren_q     <= 1'b0;
      rd_addr_q  <= 5'd0;
      reg_data_q <= 32'd0;
      rd_q[0]    <= 5'd0;
      rd_q[1]    <= 5'd0;
      dat_q[0]   <= 32'd0;
      dat_q[1]   <= 32'd0;
    end else begin
      if (push) begin
        rd_q[wp_q]  <= ld_rd;
        dat_q[wp_q] <= ld_data;
      end
      vld_q      <= vld_d;
      rp_q       <= rp_d;
      wp_q       <= wp_d;
      cnt_q      <= cnt_d;
      stall_q    <= cnt_q == 2'd2 && vld_q == 2'b11;
      wren_q     <= wren_d;
      rd_addr_q  <= rd_addr_d;
      reg_data_q <= reg_data_d;
    end
  end

  assign alu_stall = stall_q;
  assign wren      = wren_q;
  assign rd_addr   = rd_addr_q;
  assign reg_data  = reg_data_q;
endmodule

// File: tb/tb_wb_arb.sv
// tb_wb_arb: directed self-checking bench for wb_arb.
module tb_wb_arb;
  logic        clk = 1'b0;
  logic        rst_n, alu_valid, ld_valid, ld_ready, alu_stall, wren;
  logic [4:0]  alu_rd, ld_rd, rd_addr;
  logic [31:0] alu_data, ld_data, reg_data;
  int n_tests = 0;
  int n_fail = 0;

  wb_arb dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .alu_stall(alu_stall), .wren(wren), .rd_addr(rd_addr), .reg_data(reg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ldd);
    alu_valid = av; alu_rd = ar; alu_data = ad;
    ld_valid = lv; ld_rd = lr; ld_data = ldd;
  endtask

  task automatic wr(input string tag, input logic [4:0] r, input logic [31:0] d);
    check({tag, "_wren"}, 32'(wren), 32'd1);
    check({tag, "_rd"}, 32'(rd_addr), 32'(r));
    check({tag, "_data"}, reg_data, d);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    cyc(); cyc();
    check("rst_wren", 32'(wren), 0);
    check("rst_rd", 32'(rd_addr), 0);
    check("rst_data", reg_data, 0);
    check("rst_stall", 32'(alu_stall), 0);
    check("rst_ready", 32'(ld_ready), 0);
    rst_n = 1'b1;
    cyc();
    check("rel_ready", 32'(ld_ready), 1);
    check("rel_wren", 32'(wren), 0);

    drive(1, 5, 32'h12345678, 0, 0, 0);
    cyc(); wr("alu5", 5, 32'h12345678);
    drive(0, 0, 0, 0, 0, 0);
    cyc();
    check("idle_wren", 32'(wren), 0);
    check("hold_rd", 32'(rd_addr), 5);
    check("hold_data", reg_data, 32'h12345678);

    drive(1, 7, 32'h70, 1, 3, 32'hA);
    check("fill_rdy0", 32'(ld_ready), 1);
    cyc(); wr("fill_a", 7, 32'h70);
    drive(1, 7, 32'h71, 1, 4, 32'hB);
    check("fill_rdy1", 32'(ld_ready), 1);
    cyc(); wr("fill_b", 7, 32'h71);
    check("fill_stall0", 32'(alu_stall), 0);
    drive(1, 7, 32'h72, 1, 8, 32'hC);
    check("full_rdy", 32'(ld_ready), 0);
    cyc(); wr("fill_c", 7, 32'h72);
    check("full_stall", 32'(alu_stall), 1);
    drive(0, 0, 0, 0, 0, 0);
    cyc(); wr("drain3", 3, 32'hA);
    check("drain_stall", 32'(alu_stall), 1);
    cyc(); wr("drain4", 4, 32'hB);
    check("drain_unstall", 32'(alu_stall), 0);
    cyc();
    check("drain_empty", 32'(wren), 0);

    drive(1, 7, 32'h77, 1, 9, 32'h1);
    cyc(); wr("waw_a", 7, 32'h77);
    drive(1, 9, 32'h2, 0, 0, 0);
    cyc(); wr("waw_alu", 9, 32'h2);
    drive(0, 0, 0, 0, 0, 0);
    cyc(); check("waw_noload0", 32'(wren), 0);
    cyc(); check("waw_noload1", 32'(wren), 0);

    drive(1, 6, 32'hC, 1, 6, 32'hD);
    cyc(); wr("same6", 6, 32'hC);
    drive(0, 0, 0, 0, 0, 0);
    cyc(); check("same6_none0", 32'(wren), 0);
    cyc(); check("same6_none1", 32'(wren), 0);

    drive(1, 0, 32'h99, 1, 0, 32'h55);
    check("x0_ready", 32'(ld_ready), 1);
    cyc(); check("x0_wren", 32'(wren), 0);
    drive(0, 0, 0, 0, 0, 0);
    cyc(); check("x0_wren1", 32'(wren), 0);
    check("x0_hold_rd", 32'(rd_addr), 6);

    drive(0, 0, 0, 1, 10, 32'h10);
    cyc(); check("pp_lat", 32'(wren), 0);
    drive(0, 0, 0, 1, 11, 32'h11);
    cyc(); wr("pp_10", 10, 32'h10);
    check("pp_ready", 32'(ld_ready), 1);
    drive(0, 0, 0, 0, 0, 0);
    cyc(); wr("pp_11", 11, 32'h11);
    cyc(); check("pp_empty", 32'(wren), 0);

    drive(1, 7, 32'h7A, 1, 12, 32'h1);
    cyc();
    drive(1, 7, 32'h7B, 1, 13, 32'h2);
    cyc();
    drive(1, 12, 32'h3, 0, 0, 0);
    cyc(); wr("kill_alu", 12, 32'h3);
    drive(0, 0, 0, 0, 0, 0);
    cyc(); wr("kill_next", 13, 32'h2);
    cyc(); check("kill_empty", 32'(wren), 0);

    drive(1, 7, 32'h7C, 1, 20, 32'h20);
    cyc();
    drive(1, 7, 32'h7D, 1, 21, 32'h21);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    check("mid_rst_ready", 32'(ld_ready), 0);
    cyc();
    check("mid_rst_wren", 32'(wren), 0);
    check("mid_rst_stall", 32'(alu_stall), 0);
    rst_n = 1'b1;
    cyc();
    check("post_rst_ready", 32'(ld_ready), 1);
    check("post_rst_wren", 32'(wren), 0);
    cyc();
    check("post_rst_wren1", 32'(wren), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
